// File: rtl/regbank_pkg.sv
// Shared types and default widths for the register-bank command sequencer.
// The opcode and state encodings are fixed, so external tools may decode them.
package regbank_pkg;

   localparam int RB_DATA_W = 8;
   localparam int RB_ADDR_W = 2;

   typedef enum logic [2:0] {
      OP_LDI = 3'b000,
      OP_MOV = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_SHL = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/regbank_seq_ctrl_if.sv
// Command, bank and response signals of the sequencer, bundled as one interface.
// Handshakes: a transfer happens at a rising edge where valid and ready are both 1;
// valid and its payload hold steady until that edge, and ready may be high early.
interface regbank_seq_ctrl_if
   import regbank_pkg::*;
   #(parameter int DATA_W = RB_DATA_W,
     parameter int ADDR_W = RB_ADDR_W);

   logic              cmd_valid;
   logic              cmd_ready;
   op_t               cmd_op;
   logic [ADDR_W-1:0] cmd_rd;
   logic [ADDR_W-1:0] cmd_rs0;
   logic [ADDR_W-1:0] cmd_rs1;
   logic [DATA_W-1:0] cmd_imm;

   logic [ADDR_W-1:0] add_rd0;
   logic [ADDR_W-1:0] add_rd1;
   logic [DATA_W-1:0] rd0;
   logic [DATA_W-1:0] rd1;
   logic              wr_en;
   logic [ADDR_W-1:0] add_wr;
   logic [DATA_W-1:0] wr_data;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              resp_zero;
   logic              resp_carry;
   logic              busy;

   modport master (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_imm,
      input  rd0, rd1, resp_ready,
      output cmd_ready, add_rd0, add_rd1, wr_en, add_wr, wr_data,
      output resp_valid, resp_data, resp_zero, resp_carry, busy
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_imm,
      output rd0, rd1, resp_ready,
      input  cmd_ready, add_rd0, add_rd1, wr_en, add_wr, wr_data,
      input  resp_valid, resp_data, resp_zero, resp_carry, busy
   );

endinterface

// File: rtl/regbank_alu.sv
// Combinational ALU for the sequencer; all results wrap modulo 2**DATA_W.
// For SUB, carry is the borrow, i.e. it is set when a < b.
module regbank_alu
   import regbank_pkg::*;
   #(parameter int DATA_W = RB_DATA_W)
   (
   input  op_t               op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              carry
   );

   logic [DATA_W:0] wide;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      wide   = '0;
      case (op)
         OP_LDI: result = imm;
         OP_MOV: result = a;
         OP_ADD: begin
            wide   = {1'b0, a} + {1'b0, b};
            result = wide[DATA_W-1:0];
            carry  = wide[DATA_W];
         end
         OP_SUB: begin
            // The extra top bit of the zero-extended difference is the borrow.
            wide   = {1'b0, a} - {1'b0, b};
            result = wide[DATA_W-1:0];
            carry  = wide[DATA_W];
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: begin
            result = {a[DATA_W-2:0], 1'b0};
            carry  = a[DATA_W-1];
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/regbank_seq_ctrl.sv
// Sequencer that runs READ -> WRITE -> RESP on the register bank for each command.
// It is the bank's only writer; the FSM state is exported on dbg_state.
module regbank_seq_ctrl
   import regbank_pkg::*;
   #(parameter int DATA_W = RB_DATA_W,
     parameter int ADDR_W = RB_ADDR_W)
   (
   input  logic         clock,
   input  logic         reset,
   regbank_seq_ctrl_if.master bus,
   output state_t       dbg_state
   );

   state_t            state;
   op_t               cap_op;
   logic [ADDR_W-1:0] cap_rd;
   logic [ADDR_W-1:0] cap_rs0;
   logic [ADDR_W-1:0] cap_rs1;
   logic [DATA_W-1:0] cap_imm;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] res_data;
   logic              res_zero;
   logic              res_carry;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;

   regbank_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (cap_op),
      .a      (opa),
      .b      (opb),
      .imm    (cap_imm),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cap_op    <= OP_LDI;
         cap_rd    <= '0;
         cap_rs0   <= '0;
         cap_rs1   <= '0;
         cap_imm   <= '0;
         opa       <= '0;
         opb       <= '0;
         res_data  <= '0;
         res_zero  <= 1'b0;
         res_carry <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid) begin
               cap_op  <= bus.cmd_op;
               cap_rd  <= bus.cmd_rd;
               cap_rs0 <= bus.cmd_rs0;
               cap_rs1 <= bus.cmd_rs1;
               cap_imm <= bus.cmd_imm;
               state   <= READ;
            end
            // Operands are latched here, so rd may alias rs0/rs1 without a hazard.
            READ: begin
               opa   <= bus.rd0;
               opb   <= bus.rd1;
               state <= WRITE;
            end
            WRITE: begin
               res_data  <= alu_result;
               res_zero  <= (alu_result == '0);
               res_carry <= alu_carry;
               state     <= RESP;
            end
            RESP: if (bus.resp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Bank strobes are gated by state so they read as zero outside their cycle.
   always_comb begin
      bus.cmd_ready  = (state == IDLE);
      bus.busy       = (state != IDLE);
      bus.add_rd0    = '0;
      bus.add_rd1    = '0;
      bus.wr_en      = 1'b0;
      bus.add_wr     = '0;
      bus.wr_data    = '0;
      bus.resp_valid = (state == RESP);
      bus.resp_data  = res_data;
      bus.resp_zero  = res_zero;
      bus.resp_carry = res_carry;
      if (state == READ) begin
         bus.add_rd0 = cap_rs0;
         bus.add_rd1 = cap_rs1;
      end
      if (state == WRITE) begin
         bus.wr_en   = 1'b1;
         bus.add_wr  = cap_rd;
         bus.wr_data = alu_result;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_regbank_seq_ctrl.sv
// Bench for regbank_seq_ctrl: models the 4x8 bank, drives directed and random
// commands, and checks against an arithmetic reference of the register file.
module tb_regbank_seq_ctrl;
   import regbank_pkg::*;

   logic   clock;
   logic   reset;
   state_t dbg_state;

   regbank_seq_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bus ();

   regbank_seq_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Bank storage: combinational reads, write on the rising edge.
   logic [7:0] bank [4] = '{default: 8'h00};
   assign bus.rd0 = bank[bus.add_rd0];
   assign bus.rd1 = bank[bus.add_rd1];
   always @(posedge clock) if (bus.wr_en) bank[bus.add_wr] <= bus.wr_data;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_reg [4] = '{default: 8'h00};
   logic [9:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: the opcode rules written as plain integer arithmetic.
   function automatic void ref_op(input int op, input int a, input int b, input int imm,
                                  output int res, output bit cy);
      res = 0;
      cy  = 1'b0;
      case (op)
         0: res = imm;
         1: res = a;
         2: begin res = (a + b) % 256; cy = (a + b) > 255; end
         3: begin res = (a - b + 256) % 256; cy = (a < b); end
         4: res = a & b;
         5: res = a | b;
         6: res = a ^ b;
         7: begin res = (a * 2) % 256; cy = (a >= 128); end
         default: res = 0;
      endcase
   endfunction

   // Every bank write must match the next expected {addr, data}.
   always @(negedge clock) begin
      if (reset && bus.wr_en) begin
         if (exp_q.size() == 0) check("unexpected_write", {bus.add_wr, bus.wr_data}, 32'h0);
         else check("write_addr_data", {bus.add_wr, bus.wr_data}, exp_q.pop_front());
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_wr_en"}, bus.wr_en, 0);
      check({tag, "_resp_valid"}, bus.resp_valid, 0);
      check({tag, "_addrs"}, {bus.add_rd0, bus.add_rd1, bus.add_wr}, 0);
      check({tag, "_wr_data"}, bus.wr_data, 0);
      check({tag, "_state"}, dbg_state, IDLE);
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < 4; i++) check(tag, bank[i], exp_reg[i]);
   endtask

   task automatic do_cmd(input int op, input int rd, input int rs0, input int rs1,
                         input int imm, input int delay);
      int         res;
      bit         cy;
      logic [7:0] r8;
      ref_op(op, exp_reg[rs0], exp_reg[rs1], imm, res, cy);
      r8 = res[7:0];
      exp_q.push_back({rd[1:0], r8});
      @(negedge clock);
      check("ready_before_cmd", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op_t'(op[2:0]);
      bus.cmd_rd    = rd[1:0];
      bus.cmd_rs0   = rs0[1:0];
      bus.cmd_rs1   = rs1[1:0];
      bus.cmd_imm   = imm[7:0];
      @(negedge clock);
      bus.cmd_valid  = 1'b0;
      bus.resp_ready = (delay == 0);
      check("read_addr", {bus.add_rd0, bus.add_rd1}, {rs0[1:0], rs1[1:0]});
      check("read_ready_low", bus.cmd_ready, 0);
      check("read_no_write", bus.wr_en, 0);
      @(negedge clock);
      check("write_en", bus.wr_en, 1);
      check("write_data", {bus.add_wr, bus.wr_data}, {rd[1:0], r8});
      check("write_busy", bus.busy, 1);
      @(negedge clock);
      check("resp_valid", bus.resp_valid, 1);
      check("resp_flags", {bus.resp_data, bus.resp_zero, bus.resp_carry}, {r8, r8 == 8'h00, cy});
      check("resp_no_write", bus.wr_en, 0);
      for (int i = 0; i < delay; i++) begin
         if (i == 0) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = op_t'($urandom_range(0, 7));
            bus.cmd_rd    = 2'($urandom_range(0, 3));
            bus.cmd_imm   = 8'($urandom_range(0, 255));
         end
         @(negedge clock);
         check("resp_hold_valid", bus.resp_valid, 1);
         check("resp_hold_data", {bus.resp_data, bus.resp_zero, bus.resp_carry}, {r8, r8 == 8'h00, cy});
         check("resp_hold_ready_low", bus.cmd_ready, 0);
      end
      bus.cmd_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clock);
      check("after_resp_valid", bus.resp_valid, 0);
      check("after_resp_ready", bus.cmd_ready, 1);
      bus.resp_ready = 1'b0;
      exp_reg[rd] = r8;
      check("write_count", exp_q.size(), 0);
      check_bank("bank_vs_model");
   endtask

   initial begin
      reset          = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = OP_LDI;
      bus.cmd_rd     = '0;
      bus.cmd_rs0    = '0;
      bus.cmd_rs1    = '0;
      bus.cmd_imm    = '0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      check("reset_resp", {bus.resp_data, bus.resp_zero, bus.resp_carry}, 0);
      reset = 1'b1;

      do_cmd(0, 1, 0, 0, 8'h05, 0);
      check("ldi_r1", bank[1], 8'h05);

      do_cmd(0, 1, 0, 0, 8'hF0, 1);
      do_cmd(0, 2, 0, 0, 8'h20, 0);
      do_cmd(2, 3, 1, 2, 0, 2);
      check("add_r3", bank[3], 8'h10);

      do_cmd(0, 1, 0, 0, 8'h10, 0);
      do_cmd(0, 2, 0, 0, 8'h10, 0);
      do_cmd(3, 1, 1, 2, 0, 0);
      check("sub_r1", bank[1], 8'h00);
      do_cmd(0, 0, 0, 0, 8'h00, 0);
      do_cmd(3, 0, 0, 2, 0, 1);
      check("sub_r0", bank[0], 8'hF0);

      do_cmd(0, 2, 0, 0, 8'h81, 0);
      do_cmd(7, 3, 2, 0, 0, 5);
      check("shl_r3", bank[3], 8'h02);

      // Reset lands in the WRITE cycle before the edge: the write must be lost.
      do_cmd(0, 3, 0, 0, 8'h77, 0);
      exp_q.push_back({2'd3, 8'h81});
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_ADD;
      bus.cmd_rd    = 2'd3;
      bus.cmd_rs0   = 2'd1;
      bus.cmd_rs1   = 2'd2;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      @(negedge clock);
      check("rstw_wr_en", bus.wr_en, 1);
      #2 reset = 1'b0;
      #1 check_idle_outputs("rstw");
      @(negedge clock);
      reset = 1'b1;
      repeat (2) begin
         @(negedge clock);
         check("rstw_no_resp", bus.resp_valid, 0);
      end
      check("rstw_bank_r3", bank[3], 8'h77);
      check("rstw_queue", exp_q.size(), 0);

      // Reset during READ.
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_XOR;
      bus.cmd_rd    = 2'd0;
      bus.cmd_rs0   = 2'd2;
      bus.cmd_rs1   = 2'd3;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      check("rstr_state", dbg_state, READ);
      reset = 1'b0;
      #1 check_idle_outputs("rstr");
      check("rstr_resp", {bus.resp_data, bus.resp_zero, bus.resp_carry}, 0);
      @(negedge clock);
      reset = 1'b1;
      check_bank("rstr_bank");

      for (int k = 0; k < 24; k++) begin
         do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      end

      check("final_queue", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regbank_seq_ctrl.md
Name: regbank_seq_ctrl

Overview:
- Command sequencer that drives the 4x8 register bank (2 combinational read ports, 1 synchronous write port).
- Accepts one register-to-register operation per valid/ready handshake and runs a fixed READ -> WRITE -> RESP sequence on the bank.
- Computes the result through an internal ALU, writes it back, and returns the result plus flags on a response handshake.
- Sits between the upstream instruction source and the bank; it is the only writer of the bank.

Parameters:
- DATA_W, 8, register and ALU data width.
- ADDR_W, 2, register address width (2**ADDR_W registers).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode (op_t).
- cmd_rd  in  ADDR_W  destination register.
- cmd_rs0  in  ADDR_W  source A.
- cmd_rs1  in  ADDR_W  source B.
- cmd_imm  in  DATA_W  immediate, used by LDI only.
- add_rd0  out  ADDR_W  bank read address 0.
- add_rd1  out  ADDR_W  bank read address 1.
- rd0  in  DATA_W  bank read data 0.
- rd1  in  DATA_W  bank read data 1.
- wr_en  out  1  bank write enable.
- add_wr  out  ADDR_W  bank write address.
- wr_data  out  DATA_W  bank write data.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  DATA_W  value written to rd.
- resp_zero  out  1  resp_data == 0.
- resp_carry  out  1  carry/borrow flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset low, async): state=IDLE; captured command, operand A/B, result and flags all 0. Outputs: cmd_ready=1, wr_en=0, resp_valid=0, busy=0, all address/data outputs 0.
- Opcodes: 000 LDI (imm); 001 MOV (A); 010 ADD (A+B); 011 SUB (A-B); 100 AND; 101 OR; 110 XOR; 111 SHL (A<<1).
- Carry: ADD = carry out of bit DATA_W-1; SUB = borrow (A<B); SHL = old A[DATA_W-1]; all other ops = 0.
- Arithmetic wraps modulo 2**DATA_W.
- IDLE: cmd_ready=1. When cmd_valid=1 at edge E0, capture op/rd/rs0/rs1/imm and go to READ.
- READ: add_rd0=rs0, add_rd1=rs1 (captured values). At E1 latch A=rd0, B=rd1; go to WRITE.
- WRITE: wr_en=1, add_wr=rd, wr_data=ALU(op,A,B,imm), for exactly one cycle. At E2 the bank stores the value; resp_data/flags are registered; go to RESP.
- RESP: resp_valid=1 and held stable until resp_ready=1 at an edge, then go to IDLE.
- Latency: write occurs at E0+2; resp_valid is first high in the cycle after E0+2.
- Throughput: at most 1 command per 4 cycles with no response backpressure. cmd_ready=0 in every state except IDLE.
- Outside READ: add_rd0 = add_rd1 = 0. Outside WRITE: wr_en=0 and add_wr/wr_data=0.
- rd equal to rs0 or rs1: operands were latched in READ, so the new value is written normally (no hazard).
- cmd_valid while busy: ignored; cmd_* fields are don't-care.
- resp_ready already high when resp_valid rises: handshake completes at the next edge; controller is back in IDLE one cycle later.
- Reset mid-operation: return to IDLE immediately. A WRITE not yet clocked is lost; no partial write; resp_valid drops.

Decomposition:
- regbank_pkg holds: DATA_W/ADDR_W defaults, op_t enum (8 opcodes above), state_t enum {IDLE, READ, WRITE, RESP}.
- One sub-module: regbank_alu, purely combinational (op, a, b, imm -> result, carry). Zero flag is computed in the controller.

Test Plan:
- Reset low mid-stream, then release -> cmd_ready=1, busy=0, wr_en=0, resp_valid=0, all outputs 0.
- LDI rd=1 imm=0x05 -> single wr_en pulse at E0+2 with add_wr=1, wr_data=0x05; resp_data=0x05, zero=0, carry=0.
- Preload r1=0xF0, r2=0x20; ADD rd=3 rs0=1 rs1=2 -> add_rd0=1/add_rd1=2 in READ; wr_data=0x10, resp_carry=1, resp_zero=0.
- r1=0x10, r2=0x10: SUB rd=1 rs0=1 rs1=2 -> r1=0x00, zero=1, carry=0. Then SUB rd=0 rs0=0 rs1=2 (r0=0) -> 0xF0, carry=1.
- SHL rs0=r2=0x81 with resp_ready held low 5 cycles -> resp_valid and resp_data=0x02 (carry=1) held stable; cmd_ready=0 until handshake; second cmd_valid ignored.
- Assert reset during WRITE cycle before the edge -> no bank write (destination keeps old value), state IDLE, resp_valid never asserted.
